lsu: RTL and testbench



---
 rtl/lsu.sv | 136 +++++++++++++
 tb/tb_lsu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit between the datapath and the dm word memory.
// Byte/half/word loads and stores over a req/done handshake; sub-word stores
// are done as read-modify-write of the containing big-endian word.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [9:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [7:0]  dm_addr,
  output logic [31:0] dm_din,
  output logic        dm_write,
  output logic        dm_read,
  input  logic [31:0] dm_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        sx_q;
  logic        err_q;
  logic [31:0] wdata_q;
  logic        accept;
  logic        illegal;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept  = (state == IDLE) && req;
  assign illegal = (size == 2'b11) ||
                   ((size == 2'b01) && addr[0]) ||
                   ((size == 2'b10) && (addr[1:0] != 2'b00));

  // Outputs decoded from state only; reset drops the strobes asynchronously.
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign err      = (state == DONE) && err_q;
  assign dm_read  = (state == READ);
  assign dm_write = (state == WRITE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (illegal)                          state_next = DONE;
          else if (we && (size == 2'b10))       state_next = WRITE;
          else                                  state_next = READ;
        end
      end
      READ:    state_next = we_q ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction and extension for loads (big-endian: offset 0 is [31:24]).
  always_comb begin
    byte_lane = dm_dout[{~off_q, 3'b000} +: 8];
    half_lane = dm_dout[{~off_q[1], 4'b0000} +: 16];
    load_val  = dm_dout;
    case (size_q)
      2'b00:   load_val = {{24{sx_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_val = {{16{sx_q & half_lane[15]}}, half_lane};
      default: load_val = dm_dout;
    endcase
  end

  // Old word with only the target lane replaced, for sub-word stores.
  always_comb begin
    merged = dm_dout;
    case (size_q)
      2'b00:   merged[{~off_q, 3'b000} +: 8]     = wdata_q[7:0];
      2'b01:   merged[{~off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Request latch, dm address/data registers and load result.
  // dm_din doubles as the merge register: READ of a sub-word store loads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q   <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      sx_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata   <= '0;
      dm_addr <= '0;
      dm_din  <= '0;
    end else begin
      if (accept) begin
        off_q   <= addr[1:0];
        size_q  <= size;
        we_q    <= we;
        sx_q    <= sign_ext;
        wdata_q <= wdata;
        err_q   <= illegal;
        if (!illegal) begin
          dm_addr <= addr[9:2];
          if (we && (size == 2'b10)) dm_din <= wdata;
        end
      end
      if (state == READ) begin
        if (we_q) dm_din <= merged;
        else      rdata  <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a transaction-level model predicts the
// per-cycle handshake, dm strobes and load results from the access rules.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err, dm_write, dm_read;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [7:0]  dm_addr;

  lsu dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_write(dm_write),
    .dm_read(dm_read), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  // dm: asynchronous read, synchronous write
  logic [31:0] dm_mem [256];
  assign dm_dout = dm_mem[dm_addr];
  always @(posedge clk) if (dm_write) dm_mem[dm_addr] <= dm_din;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    bit          bsy, rd, wr, dn, er, ca, cd, sr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] r;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_rdata = '0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, against the model's expectation (idle if none).
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      exp_t e;
      e = '{c: 0, bsy: 0, rd: 0, wr: 0, dn: 0, er: 0, ca: 0, cd: 0, sr: 0,
            a: '0, d: '0, r: '0};
      if (q.size() > 0 && q[0].c == cyc) e = q.pop_front();
      if (e.sr) exp_rdata = e.r;
      chk("busy", {31'b0, busy}, {31'b0, e.bsy});
      chk("dm_read", {31'b0, dm_read}, {31'b0, e.rd});
      chk("dm_write", {31'b0, dm_write}, {31'b0, e.wr});
      chk("done", {31'b0, done}, {31'b0, e.dn});
      chk("err", {31'b0, err}, {31'b0, e.er});
      if (e.ca) chk("dm_addr", {24'b0, dm_addr}, {24'b0, e.a});
      if (e.cd) chk("dm_din", dm_din, e.d);
      chk("rdata", rdata, exp_rdata);
    end
  end

  function automatic exp_t mk(input int c);
    mk = '{c: c, bsy: 1, rd: 0, wr: 0, dn: 0, er: 0, ca: 0, cd: 0, sr: 0,
           a: '0, d: '0, r: '0};
  endfunction

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the first
  // IDLE cycle after the access.
  task automatic issue(input bit w, input logic [1:0] s, input bit sx,
                       input logic [9:0] a, input logic [31:0] wd, input bit poke);
    int          off, nb, sh;
    logic [7:0]  wa;
    logic [31:0] mask, v;
    exp_t        e;
    off = int'(a[1:0]);
    wa  = a[9:2];
    if (s == 2'b11 || (s == 2'b01 && a[0]) || (s == 2'b10 && off != 0)) begin
      e = mk(cyc + 1); e.dn = 1; e.er = 1; q.push_back(e);
    end else begin
      nb   = (s == 2'b00) ? 8 : (s == 2'b01) ? 16 : 32;
      sh   = 32 - 8 * off - nb;
      mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 1);
      if (!w) begin
        v = (ref_mem[wa] >> sh) & mask;
        if (sx && v[nb-1]) v = v | ~mask;
        e = mk(cyc + 1); e.rd = 1; e.ca = 1; e.a = wa; q.push_back(e);
        e = mk(cyc + 2); e.dn = 1; e.sr = 1; e.r = v; q.push_back(e);
      end else if (nb == 32) begin
        ref_mem[wa] = wd;
        e = mk(cyc + 1); e.wr = 1; e.ca = 1; e.a = wa; e.cd = 1; e.d = wd; q.push_back(e);
        e = mk(cyc + 2); e.dn = 1; q.push_back(e);
      end else begin
        v = (ref_mem[wa] & ~(mask << sh)) | ((wd & mask) << sh);
        ref_mem[wa] = v;
        e = mk(cyc + 1); e.rd = 1; e.ca = 1; e.a = wa; q.push_back(e);
        e = mk(cyc + 2); e.wr = 1; e.ca = 1; e.a = wa; e.cd = 1; e.d = v; q.push_back(e);
        e = mk(cyc + 3); e.dn = 1; q.push_back(e);
      end
    end
    req = 1'b1; we = w; size = s; sign_ext = sx; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; we = ~w; size = 2'b10; sign_ext = ~sx; addr = 10'h3FC; wdata = 32'h5A5A_5A5A;
    if (poke) begin
      req = 1'b1; we = 1'b1; size = 2'b10; addr = 10'h000; wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      req = 1'b0;
    end
    for (int i = 0; i < 12 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL timeout: %0d expected cycles not reached", q.size());
      q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dm_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    dm_mem[2]  = 32'h1234_5678;
    ref_mem[2] = 32'h1234_5678;

    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_dm_addr", {24'b0, dm_addr}, 32'd0);
    chk("rst_dm_din", dm_din, 32'd0);
    chk("rst_dm_wr", {31'b0, dm_write}, 32'd0);
    chk("rst_dm_rd", {31'b0, dm_read}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    issue(1, 2'b10, 0, 10'h004, 32'hAABB_CCDD, 0);
    chk("word_store_mem", dm_mem[1], 32'hAABB_CCDD);
    issue(0, 2'b10, 0, 10'h004, 32'h0, 0);
    chk("word_load", rdata, 32'hAABB_CCDD);

    issue(1, 2'b00, 0, 10'h005, 32'h0000_0011, 1);
    chk("rmw_din", dm_din, 32'hAA11_CCDD);
    issue(0, 2'b10, 0, 10'h004, 32'h0, 0);
    chk("rmw_load", rdata, 32'hAA11_CCDD);

    issue(0, 2'b00, 1, 10'h006, 32'h0, 0);
    chk("lb_sx", rdata, 32'hFFFF_FFCC);
    issue(0, 2'b00, 0, 10'h006, 32'h0, 0);
    chk("lb_zx", rdata, 32'h0000_00CC);
    issue(0, 2'b01, 1, 10'h004, 32'h0, 0);
    chk("lh_sx", rdata, 32'hFFFF_AA11);

    issue(1, 2'b01, 0, 10'h005, 32'h0000_FFFF, 0);
    issue(0, 2'b10, 0, 10'h006, 32'h0, 0);
    issue(0, 2'b11, 1, 10'h004, 32'h0, 0);
    chk("rej_rdata", rdata, 32'hFFFF_AA11);
    chk("rej_mem", dm_mem[1], 32'hAA11_CCDD);

    issue(1, 2'b01, 0, 10'h00E, 32'h1234_BEEF, 1);
    issue(1, 2'b00, 0, 10'h00F, 32'hFFFF_FF77, 0);
    issue(0, 2'b10, 0, 10'h00C, 32'h0, 0);
    chk("b2b_load", rdata, 32'h0000_BE77);

    // Reset during the READ cycle of a byte store to word 2
    chk_en = 1'b0;
    req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 10'h008; wdata = 32'h99;
    @(posedge clk); #1;
    req = 1'b0;
    #2;
    chk("abort_pre_rd", {31'b0, dm_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_rd", {31'b0, dm_read}, 32'd0);
    chk("abort_wr", {31'b0, dm_write}, 32'd0);
    exp_rdata = '0;
    @(posedge clk); #1;
    chk("abort_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_mem", dm_mem[2], 32'h1234_5678);
    issue(0, 2'b10, 0, 10'h008, 32'h0, 0);
    chk("abort_load", rdata, 32'h1234_5678);

    chk_en = 1'b0;
    for (int i = 0; i < 256; i++) chk($sformatf("mem[%0d]", i), dm_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
